// File: rtl/mc_control_fsm.sv
// -----------------------------------------------------------------------------
// mc_control_fsm
//   Multi-cycle MIPS control sequencer. Fetches an instruction, latches it into
//   the decoder, classifies op/funct once in DECODE and then walks the
//   instruction through EXEC, MEM, WB or MULDIV, emitting one-hot style enables
//   for the PC, ALU, data memory, register file and HI/LO unit.
//
// Parameters
//   MULDIV_CYCLES  cycles spent in MULDIV for mult/multu/div/divu (>= 1)
//
// Ports
//   clk        in   rising-edge clock
//   rest       in   asynchronous active-low reset
//   op         in   [5:0] opcode field (instr[31:26])
//   funct      in   [5:0] funct field (instr[5:0])
//   imem_ack   in   instruction memory data valid (honoured only in FETCH)
//   dmem_ack   in   data memory access complete (honoured only in MEM)
//   imem_req   out  instruction fetch request
//   ir_load    out  latch instruction into decoder register (FETCH & imem_ack)
//   pc_inc     out  PC <= PC+4 (FETCH & imem_ack)
//   br_en      out  branch/jump PC update enable
//   alu_en     out  ALU operation enable
//   dmem_req   out  data memory request
//   dmem_we    out  data memory write, qualified by dmem_req
//   reg_write  out  register file write enable
//   md_busy    out  HI/LO multiply/divide unit busy
//   illegal    out  one-cycle pulse in DECODE for an unrecognised op/funct
//   halt       out  break executed; held until reset
//   state      out  [2:0] current state encoding (debug)
// -----------------------------------------------------------------------------
module mc_control_fsm #(
   parameter int MULDIV_CYCLES = 32
) (
   input  logic       clk,
   input  logic       rest,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       imem_ack,
   input  logic       dmem_ack,
   output logic       imem_req,
   output logic       ir_load,
   output logic       pc_inc,
   output logic       br_en,
   output logic       alu_en,
   output logic       dmem_req,
   output logic       dmem_we,
   output logic       reg_write,
   output logic       md_busy,
   output logic       illegal,
   output logic       halt,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_MULDIV = 3'd6,
      S_HALT   = 3'd7
   } state_e;

   // Instruction class captured in DECODE; it steers EXEC/MEM so that op/funct
   // only need to be looked at once.
   typedef enum logic [2:0] {
      C_ALU    = 3'd0,  // ALU R/I type: EXEC -> WB
      C_BRANCH = 3'd1,  // branches, j, jr: EXEC (br_en) -> FETCH
      C_LINK   = 3'd2,  // jal, jalr: EXEC (br_en) -> WB
      C_LOAD   = 3'd3,  // EXEC -> MEM -> WB
      C_STORE  = 3'd4,  // EXEC -> MEM (we) -> FETCH
      C_MULDIV = 3'd5   // EXEC -> MULDIV
   } cls_e;

   // A count of MULDIV_CYCLES-1 down to 0 needs clog2(MULDIV_CYCLES) bits.
   localparam int CW = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;

   state_e        state_q, state_d;
   cls_e          cls_q, cls_d;
   logic [CW-1:0] cnt_q, cnt_d;

   cls_e dec_cls;
   logic dec_valid;
   logic dec_halt;
   logic dec_nop;

   // ---------------------------------------------------------------------------
   // Instruction classifier (only consumed while in DECODE)
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no
      // path through the case statements can leave it unassigned (no latch).
      dec_cls   = C_ALU;
      dec_valid = 1'b1;
      dec_halt  = 1'b0;
      dec_nop   = 1'b0;
      if (op == 6'b000000) begin
         case (funct)
            6'b011000, 6'b011001,
            6'b011010, 6'b011011: dec_cls  = C_MULDIV;   // mult/multu/div/divu
            6'b001101:            dec_halt = 1'b1;       // break
            6'b001100:            dec_nop  = 1'b1;       // syscall
            6'b001000:            dec_cls  = C_BRANCH;   // jr
            6'b001001:            dec_cls  = C_LINK;     // jalr
            6'b000000, 6'b000010, 6'b000011,             // sll srl sra
            6'b000100, 6'b000110, 6'b000111,             // sllv srlv srav
            6'b010000, 6'b010001, 6'b010010, 6'b010011,  // mfhi mthi mflo mtlo
            6'b100000, 6'b100001, 6'b100010, 6'b100011,  // add addu sub subu
            6'b100100, 6'b100101, 6'b100110, 6'b100111,  // and or xor nor
            6'b101010, 6'b101011: dec_cls  = C_ALU;      // slt sltu
            default:              dec_valid = 1'b0;
         endcase
      end else if (op[5:3] == 3'b100) begin
         dec_cls = C_LOAD;
      end else if (op[5:3] == 3'b101) begin
         dec_cls = C_STORE;
      end else if (op[5:3] == 3'b001) begin
         dec_cls = C_ALU;                                // immediate ALU ops
      end else begin
         case (op)
            6'b000001, 6'b000100, 6'b000101,
            6'b000110, 6'b000111, 6'b000010: dec_cls = C_BRANCH; // regimm, beq.., j
            6'b000011:                       dec_cls = C_LINK;   // jal
            default:                         dec_valid = 1'b0;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rest) begin
      if (!rest) begin
         state_q <= S_IDLE;
         cls_q   <= C_ALU;
         cnt_q   <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop
         // samples its _d value from before the edge, independent of order.
         state_q <= state_d;
         cls_q   <= cls_d;
         cnt_q   <= cnt_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cls_d   = cls_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE:   state_d = S_FETCH;
         S_FETCH:  if (imem_ack) state_d = S_DECODE;
         S_DECODE: begin
            cls_d = dec_cls;
            if (!dec_valid || dec_nop) state_d = S_FETCH;
            else if (dec_halt)         state_d = S_HALT;
            else                       state_d = S_EXEC;
         end
         S_EXEC: begin
            case (cls_q)
               C_LOAD, C_STORE: state_d = S_MEM;
               C_MULDIV: begin
                  state_d = S_MULDIV;
                  cnt_d   = CW'(MULDIV_CYCLES - 1);
               end
               C_BRANCH:        state_d = S_FETCH;
               default:         state_d = S_WB;
            endcase
         end
         S_MEM: begin
            if (dmem_ack) state_d = (cls_q == C_LOAD) ? S_WB : S_FETCH;
         end
         S_WB:     state_d = S_FETCH;
         S_MULDIV: begin
            // The count reads 0 in the last busy cycle, giving exactly
            // MULDIV_CYCLES cycles in this state.
            if (cnt_q == '0) state_d = S_FETCH;
            else             cnt_d   = cnt_q - CW'(1);
         end
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Output decode (Moore, except ir_load/pc_inc which follow imem_ack in FETCH)
   // ---------------------------------------------------------------------------
   always_comb begin
      imem_req  = 1'b0;
      ir_load   = 1'b0;
      pc_inc    = 1'b0;
      br_en     = 1'b0;
      alu_en    = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      reg_write = 1'b0;
      md_busy   = 1'b0;
      illegal   = 1'b0;
      halt      = 1'b0;
      case (state_q)
         S_FETCH: begin
            imem_req = 1'b1;
            ir_load  = imem_ack;
            pc_inc   = imem_ack;
         end
         S_DECODE: illegal = !dec_valid;
         S_EXEC: begin
            alu_en = 1'b1;
            br_en  = (cls_q == C_BRANCH) || (cls_q == C_LINK);
         end
         S_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = (cls_q == C_STORE);
         end
         S_WB:     reg_write = 1'b1;
         S_MULDIV: md_busy   = 1'b1;
         S_HALT:   halt      = 1'b1;
         default:  ;
      endcase
   end

   assign state = state_q;

endmodule
